vedic_seq_mult: RTL

VEDIC_SEQ_MULT -- requirements
Module: vedic_seq_mult

---
 rtl/vedic_seq_mult.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vedic_seq_mult.sv
// -----------------------------------------------------------------------------
// vedic_seq_mult
// Sequential multiplier built on a Vedic-style split of each operand into low
// and high halves. One (WIDTH/2)x(WIDTH/2) unsigned multiplier is reused over
// four CALC cycles. Each cycle adds one shifted partial product into a
// 2*WIDTH accumulator. Signed operands are converted to magnitudes at
// acceptance. The sign is applied once, when the final sum is loaded into p.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   high only in IDLE; operands are accepted on in_valid && in_ready
//   a, b       WIDTH-bit multiplicand / multiplier
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  product available (held until out_ready)
//   out_ready  consumer accepts product
//   p          2*WIDTH-bit product; holds the last result until the next one
//   busy       high in CALC and DONE
// -----------------------------------------------------------------------------
module vedic_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int HW = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_step;
  logic [WIDTH-1:0]  r_a_mag;
  logic [WIDTH-1:0]  r_b_mag;
  logic              r_neg;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_p;
  logic              r_out_valid;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic [HW-1:0]     w_op_a;
  logic [HW-1:0]     w_op_b;
  logic [WIDTH-1:0]  w_pp;
  logic [PW-1:0]     w_pp_ext;
  logic [PW-1:0]     w_pp_shift;
  logic [PW-1:0]     w_sum;
  logic [PW-1:0]     w_result;

  // The most negative value negates to itself, which is exactly its magnitude
  // when read back as unsigned, so no extra bit is needed.
  assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // Step order: 0 = aL*bL, 1 = aL*bH, 2 = aH*bL, 3 = aH*bH.
  // Step bit 1 selects the a half, step bit 0 selects the b half.
  assign w_op_a = r_step[1] ? r_a_mag[WIDTH-1:HW] : r_a_mag[HW-1:0];
  assign w_op_b = r_step[0] ? r_b_mag[WIDTH-1:HW] : r_b_mag[HW-1:0];

  // Single shared half-width multiplier. The zero-extension only widens the
  // product to WIDTH bits.
  assign w_pp     = {{HW{1'b0}}, w_op_a} * {{HW{1'b0}}, w_op_b};
  assign w_pp_ext = {{WIDTH{1'b0}}, w_pp};

  always_comb begin
    w_pp_shift = w_pp_ext;
    unique case (r_step)
      2'd0:    w_pp_shift = w_pp_ext;
      2'd1,
      2'd2:    w_pp_shift = w_pp_ext << HW;
      default: w_pp_shift = w_pp_ext << WIDTH;
    endcase
  end

  // The sum wraps modulo 2^PW; any carry out is discarded.
  assign w_sum    = r_acc + w_pp_shift;
  assign w_result = r_neg ? -w_sum : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= 2'd0;
      r_a_mag     <= '0;
      r_b_mag     <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_step  <= 2'd0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc  <= w_sum;
          // Counter wraps 3 -> 0, so it is already cleared when DONE is entered.
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_p         <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign p         = r_p;

endmodule
